// File: rtl/array_cmd_seq.sv
// rtl/array_cmd_seq.sv - array command sequencer: one access at a time, periodic refresh
// Optional: define ARRAY_PARITY_EN for write parity generation and read parity checking.
module array_cmd_seq #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 2,
  parameter int REF_PERIOD = 1024,
  parameter int REF_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0] cmd_data_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  output logic                           array_ce_o,
  output logic                           array_we_o,
  output logic [ADDR_WIDTH-1:0]          array_addr_o,
  output logic [DATA_WIDTH-1:0]          array_wdata_o,
  output logic                           array_par_o,
  input  logic [DATA_WIDTH-1:0]          array_rdata_i,
  input  logic                           array_par_i,
  output logic                           array_ref_o,
  output logic                           rd_valid_o,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic                           rd_err_o,
  input  logic                           rd_ready_i
);

  localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;
  localparam logic [2:0] REFRESH = 3'd5;

  logic [2:0]            state;
  logic [CNT_W-1:0]      ref_cnt;
  logic                  ref_pending;
  logic                  ref_wrap;
  logic [3:0]            timer;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  wr_par;
  logic                  rd_par_err;

  assign cmd_we    = cmd_data_i[ADDR_WIDTH+DATA_WIDTH];
  assign cmd_addr  = cmd_data_i[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign cmd_wdata = cmd_data_i[DATA_WIDTH-1:0];
  assign ref_wrap  = (ref_cnt == CNT_W'(REF_PERIOD - 1));

`ifdef ARRAY_PARITY_EN
  assign wr_par     = ^cmd_wdata;
  assign rd_par_err = ^{array_rdata_i, array_par_i};
`else
  logic unused_par_i;
  assign unused_par_i = array_par_i;
  assign wr_par       = 1'b0;
  assign rd_par_err   = 1'b0;
`endif

  // A wrap seen in IDLE is serviced on the very next edge, so acceptance is held off in that cycle too.
  assign cmd_ready_o = !rst && (state == IDLE) && !ref_pending && !ref_wrap;
  assign array_ce_o  = (state == WRITE) || (state == READ);
  assign array_we_o  = (state == WRITE);
  assign array_ref_o = (state == REFRESH);
  assign rd_valid_o  = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

  // Leaving IDLE for REFRESH consumes a stale request; a wrap on that same edge re-arms it.
  // A fresh wrap in IDLE is consumed directly by the refresh it starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_pending <= 1'b0;
    end else if (state == IDLE) begin
      ref_pending <= ref_pending && ref_wrap;
    end else if (ref_wrap) begin
      ref_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      array_addr_o  <= '0;
      array_wdata_o <= '0;
      array_par_o   <= 1'b0;
      rd_data_o     <= '0;
      rd_err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_pending || ref_wrap) begin
            state <= REFRESH;
            timer <= 4'(REF_CYCLES - 1);
          end else if (cmd_valid_i && cmd_ready_o) begin
            state         <= cmd_we ? WRITE : READ;
            array_addr_o  <= cmd_addr;
            array_wdata_o <= cmd_wdata;
            array_par_o   <= wr_par;
          end
        end
        WRITE: state <= IDLE;
        READ: begin
          state <= RD_WAIT;
          timer <= 4'(RD_LAT - 1);
        end
        RD_WAIT: begin
          if (timer == 4'd0) begin
            state     <= RESP;
            rd_data_o <= array_rdata_i;
            rd_err_o  <= rd_par_err;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        RESP: begin
          if (rd_ready_i) state <= IDLE;
        end
        REFRESH: begin
          if (timer == 4'd0) state <= IDLE;
          else timer <= timer - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_cmd_seq.sv
// tb/tb_array_cmd_seq.sv - self-checking bench for array_cmd_seq with array model and reference memory
module tb_array_cmd_seq;
  localparam int AW         = 16;
  localparam int DW         = 32;
  localparam int RD_LAT     = 2;
  localparam int REF_PERIOD = 1024;
  localparam int REF_CYCLES = 4;
`ifdef ARRAY_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [AW+DW:0] cmd_data_i = '0;
  logic           cmd_valid_i = 1'b0;
  logic           cmd_ready_o;
  logic           array_ce_o;
  logic           array_we_o;
  logic [AW-1:0]  array_addr_o;
  logic [DW-1:0]  array_wdata_o;
  logic           array_par_o;
  logic [DW-1:0]  array_rdata_i;
  logic           array_par_i;
  logic           array_ref_o;
  logic           rd_valid_o;
  logic [DW-1:0]  rd_data_o;
  logic           rd_err_o;
  logic           rd_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [DW-1:0] arr [256];
  logic [DW-1:0] pipe_d [RD_LAT];
  logic          pipe_p [RD_LAT];
  logic          pipe_v [RD_LAT];
  logic [DW-1:0] ref_mem [256];
  bit            written [256];

  always #5 clk = ~clk;

  array_cmd_seq #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT),
    .REF_PERIOD(REF_PERIOD), .REF_CYCLES(REF_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .array_ce_o(array_ce_o), .array_we_o(array_we_o), .array_addr_o(array_addr_o),
    .array_wdata_o(array_wdata_o), .array_par_o(array_par_o),
    .array_rdata_i(array_rdata_i), .array_par_i(array_par_i), .array_ref_o(array_ref_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_err_o(rd_err_o), .rd_ready_i(rd_ready_i)
  );

  // Cycle index since reset release; the refresh counter should equal cyc mod REF_PERIOD.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Array: data is valid exactly RD_LAT cycles after the read strobe; parity is deliberately wrong for addr[3]=1.
  always @(posedge clk) begin
    if (array_ce_o && array_we_o) arr[array_addr_o[7:0]] <= array_wdata_o;
    pipe_v[0] <= array_ce_o && !array_we_o && !rst;
    pipe_d[0] <= arr[array_addr_o[7:0]];
    pipe_p[0] <= (^arr[array_addr_o[7:0]]) ^ array_addr_o[3];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
      pipe_p[i] <= pipe_p[i-1];
    end
  end
  assign array_rdata_i = (pipe_v[RD_LAT-1] === 1'b1) ? pipe_d[RD_LAT-1] : 32'hBAD0_BAD0;
  assign array_par_i   = (pipe_v[RD_LAT-1] === 1'b1) ? pipe_p[RD_LAT-1] : 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int stall, output int acc);
    int            budget;
    logic [DW-1:0] exp_d;
    logic          exp_err;
    budget      = 0;
    acc         = -1;
    cmd_data_i  = {we, addr, data};
    cmd_valid_i = 1'b1;
    while (cmd_ready_o !== 1'b1 && budget < 64) begin
      step();
      budget++;
    end
    if (cmd_ready_o !== 1'b1) begin
      cmd_valid_i = 1'b0;
      chk("accept_timeout", budget, 0);
      return;
    end
    acc = cyc;
    step();
    cmd_valid_i = 1'b0;
    cmd_data_i  = ~cmd_data_i;
    chk("acc_ce", array_ce_o, 1);
    chk("acc_we", array_we_o, we);
    chk("acc_addr", array_addr_o, addr);
    chk("acc_wdata", array_wdata_o, data);
    if (we) begin
      chk("wr_par", array_par_o, PAR_EN ? ^data : 1'b0);
      ref_mem[addr[7:0]] = data;
      written[addr[7:0]] = 1'b1;
      step();
      chk("ready_after_write", cmd_ready_o, 1);
      chk("ce_after_write", array_ce_o, 0);
    end else begin
      exp_d   = ref_mem[addr[7:0]];
      exp_err = PAR_EN & addr[3];
      while (cyc < acc + 1 + RD_LAT) step();
      chk("rd_valid_early", rd_valid_o, 0);
      step();
      chk("rd_valid", rd_valid_o, 1);
      chk("rd_data", rd_data_o, exp_d);
      chk("rd_err", rd_err_o, exp_err);
      for (int s = 0; s < stall; s++) begin
        step();
        chk("stall_valid", rd_valid_o, 1);
        chk("stall_data", rd_data_o, exp_d);
        chk("stall_ready", cmd_ready_o, 0);
      end
      rd_ready_i = 1'b1;
      step();
      rd_ready_i = 1'b0;
      chk("rd_valid_drop", rd_valid_o, 0);
    end
  endtask

  initial begin
    int            acc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    rst = 1'b0;
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_ce", array_ce_o, 0);
    chk("rst_we", array_we_o, 0);
    chk("rst_addr", array_addr_o, 0);
    chk("rst_wdata", array_wdata_o, 0);
    chk("rst_par", array_par_o, 0);
    chk("rst_ref", array_ref_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_rd_err", rd_err_o, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", cmd_ready_o, 1);

    goto(5);
    chk("w_ready_c5", cmd_ready_o, 1);
    do_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 0, acc);
    chk("w_accept_cycle", acc, 5);

    goto(10);
    do_cmd(1'b0, 16'h0010, 32'h0, 5, acc);
    chk("r_accept_cycle", acc, 10);
    chk("ready_after_resp", cmd_ready_o, 1);

    goto(30);
    do_cmd(1'b1, 16'h0008, 32'h0000_0001, 0, acc);
    do_cmd(1'b0, 16'h0008, 32'h0, 1, acc);

    for (int n = 0; n < 60 && cyc < 950; n++) begin
      a = AW'($urandom_range(0, 31));
      w = ($urandom_range(0, 1) == 1) || !written[a[7:0]];
      d = $urandom;
      repeat ($urandom_range(0, 2)) step();
      do_cmd(w, a, d, $urandom_range(0, 3), acc);
    end

    goto(1023);
    cmd_data_i  = {1'b1, 16'h0005, 32'h1234_5678};
    cmd_valid_i = 1'b1;
    chk("wrap_ready", cmd_ready_o, 0);
    chk("wrap_ref", array_ref_o, 0);
    for (int k = 0; k < REF_CYCLES; k++) begin
      step();
      chk("ref_active", array_ref_o, 1);
      chk("ref_ready", cmd_ready_o, 0);
      chk("ref_ce", array_ce_o, 0);
    end
    step();
    chk("ref_done", array_ref_o, 0);
    do_cmd(1'b1, 16'h0005, 32'h1234_5678, 0, acc);
    chk("post_ref_accept", acc, 1028);

    goto(2044);
    chk("defer_ready", cmd_ready_o, 1);
    do_cmd(1'b0, 16'h0005, 32'h0, 2, acc);
    chk("defer_accept", acc, 2044);
    chk("defer_ready_blocked", cmd_ready_o, 0);
    chk("defer_no_ref_yet", array_ref_o, 0);
    for (int k = 0; k < REF_CYCLES; k++) begin
      step();
      chk("defer_ref", array_ref_o, 1);
    end
    step();
    chk("defer_ref_done", array_ref_o, 0);
    chk("defer_ready_back", cmd_ready_o, 1);

    goto(2060);
    cmd_data_i  = {1'b0, 16'h0010, 32'h0};
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    chk("rst_read_ce", array_ce_o, 1);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_ready", cmd_ready_o, 0);
    chk("midrst_ce", array_ce_o, 0);
    chk("midrst_we", array_we_o, 0);
    chk("midrst_addr", array_addr_o, 0);
    chk("midrst_wdata", array_wdata_o, 0);
    chk("midrst_par", array_par_o, 0);
    chk("midrst_ref", array_ref_o, 0);
    chk("midrst_rd_valid", rd_valid_o, 0);
    chk("midrst_rd_data", rd_data_o, 0);
    chk("midrst_rd_err", rd_err_o, 0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", cmd_ready_o, 1);
    for (int k = 0; k < RD_LAT + 3; k++) begin
      step();
      chk("abandoned_resp", rd_valid_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
